pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the execute stage of the 5-stage pipeline CPU. It splits a WIDTH-bit add or subtract into STAGES carry-chained slices, one slice per clock. It accepts one operation per cycle under a valid/ready handshake. Results carry true carry-out, signed-overflow, negative and zero flags.

---
 rtl/pipelined_addsub.sv | 144 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: two's-complement adder/subtractor split into STAGES
// carry-chained slices, one slice per clock, under a stall-all valid/ready
// handshake. Each stage register carries the partial result, the carry out
// of its slice and only the operand slices that are still to be added, so
// the operand storage shrinks stage by stage.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             ovf,
  output logic             neg,
  output logic             zero
);

  localparam int C    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic advance;
  logic msbCarryIn_q;
  logic msbCarryIn_d;

  // The whole pipeline moves together: it may shift whenever the output
  // register is empty or is being drained this cycle.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    // Bits of a and b' that have not yet been added when entering stage k.
    localparam int IN_W = WIDTH - k * C;

    logic             vIn;
    logic             cIn;
    logic [IN_W-1:0]  remA;
    logic [IN_W-1:0]  remB;
    logic [WIDTH-1:0] resIn;
    logic [C:0]       sliceSum;
    logic             valid_q;
    logic             valid_d;
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;

    if (k == 0) begin : gHead
      // Subtraction is a + ~b + 1: invert b here and inject the +1 as the
      // first carry-in.
      assign vIn   = in_valid;
      assign cIn   = sel;
      assign remA  = a;
      assign remB  = b ^ {WIDTH{sel}};
      assign resIn = '0;
    end else begin : gBody
      assign vIn   = gStage[k-1].valid_q;
      assign cIn   = gStage[k-1].carry_q;
      assign remA  = gStage[k-1].gOps.opA_q;
      assign remB  = gStage[k-1].gOps.opB_q;
      assign resIn = gStage[k-1].result_q;
    end

    // Add this stage's slice with the incoming carry and splice it into
    // the partial result handed over by the previous stage.
    always_comb begin
      sliceSum             = {1'b0, remA[C-1:0]} + {1'b0, remB[C-1:0]} + {{C{1'b0}}, cIn};
      valid_d              = vIn;
      carry_d              = sliceSum[C];
      result_d             = resIn;
      result_d[k*C +: C]   = sliceSum[C-1:0];
    end

    // Stage register: cleared asynchronously, held while the output stalls.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q  <= 1'b0;
        carry_q  <= 1'b0;
        result_q <= '0;
      end else if (advance) begin
        valid_q  <= valid_d;
        carry_q  <= carry_d;
        result_q <= result_d;
      end
    end

    if (k < LAST) begin : gOps
      localparam int REM_W = IN_W - C;

      logic [REM_W-1:0] opA_q;
      logic [REM_W-1:0] opA_d;
      logic [REM_W-1:0] opB_q;
      logic [REM_W-1:0] opB_d;

      // Pass on only the slices the later stages still have to add.
      always_comb begin
        opA_d = remA[IN_W-1:C];
        opB_d = remB[IN_W-1:C];
      end

      // Operand register for the upper, still unprocessed slices.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opA_q <= '0;
          opB_q <= '0;
        end else if (advance) begin
          opA_q <= opA_d;
          opB_q <= opB_d;
        end
      end
    end else begin : gTail
      // Recover the carry into the MSB from the MSB sum bit and its operand
      // bits; together with the carry out it yields signed overflow.
      always_comb begin
        msbCarryIn_d = sliceSum[C-1] ^ remA[C-1] ^ remB[C-1];
      end
    end
  end

  // Carry into the MSB, kept alongside the last stage's result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msbCarryIn_q <= 1'b0;
    end else if (advance) begin
      msbCarryIn_q <= msbCarryIn_d;
    end
  end

  assign out_valid = gStage[LAST].valid_q;
  assign dout      = gStage[LAST].result_q;
  assign cout      = gStage[LAST].carry_q;
  assign ovf       = msbCarryIn_q ^ gStage[LAST].carry_q;
  assign neg       = gStage[LAST].result_q[WIDTH-1];
  // Gated by out_valid so that an empty pipeline (and reset) reports zero=0.
  assign zero      = gStage[LAST].valid_q && (gStage[LAST].result_q == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub: directed 32-bit vectors on a WIDTH=32,
// STAGES=4 instance (reset, latency, carry ripple, overflow, borrow,
// back-to-back with a stall, reset abort) plus random add/sub streams on
// four further parameterisations checked against a reference model.
module tb_pipelined_addsub;

  localparam int STG = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] d;
    logic        c;
    logic        o;
    logic        n;
    logic        z;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  f;
  } swExp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic        sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        outValid;
  logic        outReady;
  logic [31:0] dout;
  logic        cout;
  logic        ovf;
  logic        neg;
  logic        zero;

  logic        swValid;
  logic        swSel;
  logic        swOutReady;
  logic [63:0] swA;
  logic [63:0] swB;
  wire  [3:0]  swInReady;
  wire  [3:0]  swOutValid;
  wire  [3:0]  swCout;
  wire  [3:0]  swOvf;
  wire  [3:0]  swNeg;
  wire  [3:0]  swZero;
  wire  [63:0] swDout [4];

  int checks = 0;
  int errors = 0;
  int spurious = 0;
  int resultsSeen = 0;
  logic accepted;

  vec_t   vecs [13];
  vec_t   curVec;
  vec_t   expQ [$];
  swExp_t swQ [4][$];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(STG)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .sel(sel), .a(a), .b(b), .out_valid(outValid), .out_ready(outReady),
    .dout(dout), .cout(cout), .ovf(ovf), .neg(neg), .zero(zero)
  );

  for (genvar g = 0; g < 4; g++) begin : gSweep
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 32 : 64;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2  : (g == 2) ? 8  : 4;
    wire [W-1:0] d;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u (
      .clk(clk), .rst(rst), .in_valid(swValid), .in_ready(swInReady[g]),
      .sel(swSel), .a(swA[W-1:0]), .b(swB[W-1:0]),
      .out_valid(swOutValid[g]), .out_ready(swOutReady),
      .dout(d), .cout(swCout[g]), .ovf(swOvf[g]), .neg(swNeg[g]), .zero(swZero[g])
    );

    assign swDout[g] = 64'(d);
  end

  function automatic int widthOf(input int g);
    case (g)
      0:       return 8;
      1:       return 16;
      2:       return 32;
      default: return 64;
    endcase
  endfunction

  // Reference: plain wide addition of a + (b ^ sel) + sel, flags from signs.
  function automatic swExp_t refModel(input int w, input logic [63:0] x,
                                      input logic [63:0] y, input logic s);
    logic [64:0] mask;
    logic [64:0] xa;
    logic [64:0] yb;
    logic [64:0] sum;
    logic [63:0] d;
    logic        c;
    logic        o;
    logic        n;
    logic        z;
    swExp_t      r;
    mask = (65'd1 << w) - 65'd1;
    xa   = {1'b0, x} & mask;
    yb   = ({1'b0, y} ^ {65{s}}) & mask;
    sum  = xa + yb + {64'd0, s};
    d    = sum[63:0] & mask[63:0];
    c    = sum[w];
    n    = d[w-1];
    o    = (xa[w-1] == yb[w-1]) && (n != xa[w-1]);
    z    = (d == 64'd0);
    r.d  = d;
    r.f  = {c, o, n, z};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a       = v.a;
    b       = v.b;
    sel     = v.sel;
    inValid = 1'b1;
    curVec  = v;
  endtask

  // Entered 1 unit after a rising edge. Samples handshakes just before the
  // next edge, scores any result leaving, then returns 1 unit after it.
  task automatic clockCycle();
    vec_t   e;
    swExp_t s;
    #3;
    accepted = inValid && inReady;
    if (accepted) expQ.push_back(curVec);
    if (outValid && outReady) begin
      if (expQ.size() == 0) begin
        spurious++;
      end else begin
        e = expQ.pop_front();
        resultsSeen++;
        checkOutput("dout", 64'(dout), 64'(e.d));
        checkOutput("flags{c,o,n,z}", 64'({cout, ovf, neg, zero}), 64'({e.c, e.o, e.n, e.z}));
      end
    end
    for (int g = 0; g < 4; g++) begin
      if (swValid && swInReady[g]) swQ[g].push_back(refModel(widthOf(g), swA, swB, swSel));
      if (swOutValid[g] && swOutReady) begin
        if (swQ[g].size() == 0) begin
          spurious++;
        end else begin
          s = swQ[g].pop_front();
          checkOutput($sformatf("sweep%0d.dout", g), swDout[g], s.d);
          checkOutput($sformatf("sweep%0d.flags", g),
                      64'({swCout[g], swOvf[g], swNeg[g], swZero[g]}), 64'(s.f));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: checks latency, then lets the result be scored.
  task automatic runSingle(input int i);
    int lat;
    applyStimulus(vecs[i]);
    clockCycle();
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 50) begin
      clockCycle();
      lat++;
    end
    checkOutput($sformatf("latency[%0d]", i), 64'(lat), 64'(STG));
    clockCycle();
  endtask

  task automatic loadVectors();
    //             a             b             sel   dout          c     o     n     z
    vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h0001_0000, 32'h0000_FFFF, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{32'h00FF_00FF, 32'h0F0F_0F0F, 1'b1, 32'hF1EF_F1F0, 1'b0, 1'b0, 1'b1, 1'b0};
  endtask

  // Hard stop in case something upstream never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence followed by the parameter sweep.
  initial begin
    int idx;
    int cyc;
    int base;
    int stale;

    rst = 1'b1; inValid = 1'b0; sel = 1'b0; a = '0; b = '0; outReady = 1'b1;
    swValid = 1'b0; swSel = 1'b0; swA = '0; swB = '0; swOutReady = 1'b1;
    curVec = '0;
    accepted = 1'b0;
    loadVectors();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.inReady", 64'(inReady), 64'd1);
    checkOutput("rst.outValid", 64'(outValid), 64'd0);
    checkOutput("rst.dout", 64'(dout), 64'd0);
    checkOutput("rst.flags", 64'({cout, ovf, neg, zero}), 64'd0);
    checkOutput("rst.swOutValid", 64'(swOutValid), 64'd0);
    rst = 1'b0;

    $display("[TB] directed single operations");
    for (int i = 0; i < 5; i++) runSingle(i);

    $display("[TB] back-to-back stream with 3-cycle stall");
    idx = 0; cyc = 0; base = resultsSeen;
    while ((idx < 8 || expQ.size() > 0) && cyc < 100) begin
      outReady = !(cyc >= 6 && cyc < 9);
      if (idx < 8) applyStimulus(vecs[5 + idx]);
      else inValid = 1'b0;
      if (!outReady) begin
        #1;
        checkOutput("stall.inReady", 64'(inReady), 64'd0);
        checkOutput("stall.outValid", 64'(outValid), 64'd1);
        if (expQ.size() > 0) checkOutput("stall.dout", 64'(dout), 64'(expQ[0].d));
      end
      clockCycle();
      if (accepted) idx++;
      cyc++;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    checkOutput("b2b.count", 64'(resultsSeen - base), 64'd8);

    $display("[TB] reset with operations in flight");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i]);
      clockCycle();
    end
    inValid = 1'b0;
    clockCycle();
    checkOutput("abort.preValid", 64'(outValid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort.outValid", 64'(outValid), 64'd0);
    checkOutput("abort.inReady", 64'(inReady), 64'd1);
    expQ.delete();
    for (int g = 0; g < 4; g++) swQ[g].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (outValid) stale++;
      clockCycle();
    end
    checkOutput("abort.stale", 64'(stale), 64'd0);
    runSingle(2);

    $display("[TB] random sweep over four parameterisations");
    for (int n = 0; n < 200; n++) begin
      swValid = ($urandom_range(0, 3) != 0);
      swSel   = 1'($urandom_range(0, 1));
      swA     = {$urandom, $urandom};
      swB     = {$urandom, $urandom};
      if (n % 10 == 0) begin
        swA = '1;
        swB = 64'd1;
      end
      clockCycle();
    end
    swValid = 1'b0;
    repeat (12) clockCycle();
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("sweep%0d.leftover", g), 64'(swQ[g].size()), 64'd0);
    end

    checkOutput("mainLeftover", 64'(expQ.size()), 64'd0);
    checkOutput("spurious", 64'(spurious), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
